// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_WRITERS writers.
// A writer holds i_req and its data until its busy line drops for one cycle.
// That cycle carries the registered write strobe and the muxed data word.
module fifo_write_arbiter #(
    parameter int NUM_WRITERS = 4,
    parameter int DATA_WIDTH  = 8,
    localparam int IDW        = $clog2(NUM_WRITERS)
) (
    input  logic                              i_clk,
    input  logic                              i_reset,
    input  logic [NUM_WRITERS-1:0]            i_req,
    input  logic [NUM_WRITERS*DATA_WIDTH-1:0] i_data,
    output logic [NUM_WRITERS-1:0]            o_busy,
    input  logic                              i_fifo_full,
    output logic                              o_we,
    output logic [DATA_WIDTH-1:0]             o_data,
    output logic [IDW-1:0]                    o_grant_id,
    output logic [15:0]                       o_write_count
);

    typedef enum logic {IDLE, WRITE} state_t;

    state_t                  state_q, state_d;
    logic [NUM_WRITERS-1:0]  busy_q, busy_d;
    logic                    we_q, we_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [IDW-1:0]          grant_q, grant_d;
    logic [IDW-1:0]          last_q, last_d;
    logic [15:0]             count_q, count_d;

    logic                    found;
    logic [IDW-1:0]          pick;

    // First requesting writer after the last winner, wrapping to writer 0.
    always_comb begin
        int idx;
        logic [IDW-1:0] sel;
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        sel   = '0;
        for (int i = 1; i <= NUM_WRITERS; i++) begin
            idx = int'(last_q) + i;
            if (idx >= NUM_WRITERS) idx = idx - NUM_WRITERS;
            sel = IDW'(idx);
            if (!found && i_req[sel]) begin
                found = 1'b1;
                pick  = sel;
            end
        end
    end

    // Next state and registered outputs; WRITE always returns to IDLE so
    // consecutive grants are separated by one all-busy cycle.
    always_comb begin
        state_d = state_q;
        busy_d  = '1;
        we_d    = 1'b0;
        data_d  = data_q;
        grant_d = grant_q;
        last_d  = last_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (found && !i_fifo_full) begin
                    busy_d[pick] = 1'b0;
                    we_d         = 1'b1;
                    data_d       = i_data[int'(pick)*DATA_WIDTH +: DATA_WIDTH];
                    grant_d      = pick;
                    last_d       = pick;
                    count_d      = count_q + 16'd1;
                    state_d      = WRITE;
                end
            end
            WRITE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset discards any grant being registered this edge.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            busy_q  <= '1;
            we_q    <= 1'b0;
            data_q  <= '0;
            grant_q <= '0;
            last_q  <= IDW'(NUM_WRITERS - 1);
            count_q <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            we_q    <= we_d;
            data_q  <= data_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            count_q <= count_d;
        end
    end

    assign o_busy        = busy_q;
    assign o_we          = we_q;
    assign o_data        = data_q;
    assign o_grant_id    = grant_q;
    assign o_write_count = count_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: directed scenarios plus randomized traffic,
// all outputs compared every cycle against a behavioural model.
module tb_fifo_write_arbiter;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int IDW = $clog2(N);

    logic               i_clk = 1'b0;
    logic               i_reset = 1'b1;
    logic [N-1:0]       i_req = '0;
    logic [N*W-1:0]     i_data = '0;
    logic               i_fifo_full = 1'b0;
    logic [N-1:0]       o_busy;
    logic               o_we;
    logic [W-1:0]       o_data;
    logic [IDW-1:0]     o_grant_id;
    logic [15:0]        o_write_count;

    int checks = 0;
    int failures = 0;

    // Behavioural model state
    bit          m_pend;
    int          m_last;
    logic [15:0] m_cnt;
    logic [N-1:0] m_busy;
    logic        m_we;
    logic [W-1:0] m_data;
    int          m_gid;

    fifo_write_arbiter #(.NUM_WRITERS(N), .DATA_WIDTH(W)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_req(i_req), .i_data(i_data),
        .o_busy(o_busy), .i_fifo_full(i_fifo_full), .o_we(o_we),
        .o_data(o_data), .o_grant_id(o_grant_id), .o_write_count(o_write_count)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model of one clock edge given the inputs seen at that edge.
    task automatic model_edge(input logic [N-1:0] req, input logic full,
                              input logic rst, input logic [N*W-1:0] d);
        int k;
        if (rst) begin
            m_pend = 0; m_busy = '1; m_we = 0; m_data = '0; m_gid = 0;
            m_cnt = 0; m_last = N - 1;
        end else if (m_pend) begin
            m_pend = 0; m_busy = '1; m_we = 0;
        end else if (req != 0 && !full) begin
            k = -1;
            for (int off = 1; off <= N; off++)
                if (k < 0 && req[(m_last + off) % N]) k = (m_last + off) % N;
            m_busy = '1;
            m_busy[k] = 1'b0;
            m_we = 1; m_data = d[k*W +: W]; m_gid = k; m_last = k;
            m_cnt = m_cnt + 16'd1; m_pend = 1;
        end else begin
            m_busy = '1; m_we = 0;
        end
    endtask

    // Drive inputs, take one edge, then compare everything against the model.
    task automatic step(input logic [N-1:0] req, input logic full,
                        input logic rst, input logic [N*W-1:0] d);
        i_req = req; i_fifo_full = full; i_reset = rst; i_data = d;
        @(posedge i_clk);
        model_edge(req, full, rst, d);
        #1;
        chk("busy", 32'(o_busy), 32'(m_busy));
        chk("we", 32'(o_we), 32'(m_we));
        chk("data", 32'(o_data), 32'(m_data));
        chk("gid", 32'(o_grant_id), 32'(m_gid));
        chk("wcnt", 32'(o_write_count), 32'(m_cnt));
    endtask

    initial begin
        int rr_exp[8];
        int n;
        logic [N*W-1:0] d;
        logic [N-1:0] rq;
        rr_exp = '{0, 1, 2, 3, 0, 1, 2, 3};
        m_pend = 0; m_last = N - 1; m_cnt = 0; m_busy = '1; m_we = 0;
        m_data = '0; m_gid = 0;

        // Reset with everyone requesting
        step(4'hF, 0, 1, 32'h44332211);
        step(4'hF, 0, 1, 32'h44332211);
        chk("rst_busy", 32'(o_busy), 32'hF);
        chk("rst_we", 32'(o_we), 0);
        chk("rst_cnt", 32'(o_write_count), 0);
        step(4'hF, 0, 0, 32'h44332211);
        chk("first_gid", 32'(o_grant_id), 0);
        chk("first_busy", 32'(o_busy), 32'hE);
        chk("first_data", 32'(o_data), 32'h11);
        step(4'h0, 0, 0, 32'h0);

        // Single requester
        step(4'b0100, 0, 0, 32'h00A50000);
        chk("single_busy", 32'(o_busy), 32'hB);
        chk("single_we", 32'(o_we), 1);
        chk("single_data", 32'(o_data), 32'hA5);
        chk("single_gid", 32'(o_grant_id), 2);
        step(4'b0000, 0, 0, 32'h0);
        chk("single_after_busy", 32'(o_busy), 32'hF);
        chk("single_after_we", 32'(o_we), 0);

        // Round-robin from reset
        step(4'h0, 0, 1, 32'h0);
        n = 0;
        for (int c = 0; c < 16; c++) begin
            step(4'hF, 0, 0, 32'hD0C0B0A0 + 32'(c));
            if (o_we) begin
                if (n < 8) chk("rr_order", 32'(o_grant_id), 32'(rr_exp[n]));
                n++;
            end
        end
        chk("rr_grants", 32'(n), 8);
        chk("rr_wcnt", 32'(o_write_count), 8);

        // Wrap priority: last winner is 3
        step(4'b1001, 0, 0, 32'h77000066);
        chk("wrap_first", 32'(o_grant_id), 0);
        step(4'b1001, 0, 0, 32'h77000066);
        step(4'b1001, 0, 0, 32'h77000066);
        chk("wrap_second", 32'(o_grant_id), 3);
        chk("wrap_data", 32'(o_data), 32'h77);

        // Full back-pressure
        for (int c = 0; c < 5; c++) begin
            step(4'b0010, 1, 0, 32'h00003C00);
            chk("full_we", 32'(o_we), 0);
            chk("full_busy", 32'(o_busy), 32'hF);
        end
        step(4'b0010, 0, 0, 32'h00003C00);
        chk("full_release_gid", 32'(o_grant_id), 1);
        chk("full_release_we", 32'(o_we), 1);

        // Reset while the grant would be registered
        step(4'h0, 0, 1, 32'h0);
        step(4'h0, 0, 0, 32'h0);
        step(4'b0001, 0, 1, 32'h000000EE);
        chk("midrst_we", 32'(o_we), 0);
        chk("midrst_busy", 32'(o_busy), 32'hF);
        chk("midrst_cnt", 32'(o_write_count), 0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            d  = $urandom;
            rq = N'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) rq = '0;
            step(rq, ($urandom_range(0, 3) == 0), ($urandom_range(0, 99) == 0), d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
